mmio_port_responder: RTL and testbench
======================================

Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the single-cycle MIPS data-memory bus, i.e. the target side of the processor's load/store interface.
- Decodes loads and stores in a small I/O window and returns read data combinationally in the same cycle.
- Owns the PortOut register, a synchronized PortIn with change detection, and a compare timer with sticky status flags.
- Top level uses Hit to select ReadData over the RAM output and to gate the RAM write.

Parameters:
- BASE_ADDR, 32'h1001_0100, word-aligned base of the I/O window; window size 32 bytes.
- IN_WIDTH, 8, width of PortIn.
- TIMER_WIDTH, 32, width of the timer counter and compare registers.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte address from ALU result.
- WriteData  input  32  store data (rt register).
- MemWrite  input  1  store strobe for the current instruction.
- MemRead  input  1  load strobe for the current instruction.
- PortIn  input  IN_WIDTH  asynchronous external input.
- ReadData  output  32  load data, combinational.
- Hit  output  1  high when Address[31:5]==BASE_ADDR[31:5].
- PortOut  output  32  registered output port.

Behaviour:
- Reset (reset==0, asynchronous): PortOut, sync flops, STATUS, TIMER_CMP and TIMER_CNT all go to 0.
- Register map (offset = Address[4:2]; Address[1:0] ignored):
  - 0x00 PORT_OUT: read/write.
  - 0x04 PORT_IN: read-only, zero-extended synchronized value.
  - 0x08 STATUS: read-only; bit0 IN_CHG, bit1 TMR_EXP, other bits 0.
  - 0x0C TIMER_CMP: read/write.
  - 0x10 TIMER_CNT: read-only.
  - 0x14–0x1C: read 0, writes ignored.
- Read path:
  - ReadData is valid in the same cycle when MemRead & Hit.
  - ReadData is 0 when MemRead==0 or Hit==0.
- Write path:
  - The register updates on the rising edge when MemWrite & Hit.
  - Writes to read-only offsets are ignored.
- Simultaneous MemRead & MemWrite to the same offset: ReadData returns the pre-write value; the write lands at the edge.
- PortIn synchronization:
  - Two-flop synchronizer (s1, s2) plus a previous-value flop s3.
  - PORT_IN reads return s2, i.e. a PortIn change is visible after 2 edges.
  - IN_CHG sets on the edge where s2 != s3.
- STATUS clear-on-read: a flag clears at the edge where MemRead & Hit & offset==0x08. A set condition in the same cycle wins, so the flag stays 1.
- Timer:
  - TIMER_CMP==0: timer disabled, TIMER_CNT held at 0.
  - Otherwise TIMER_CNT increments every edge.
  - When TIMER_CNT==TIMER_CMP, the next edge loads 0 and sets TMR_EXP, giving a period of CMP+1 cycles.
  - Writing TIMER_CMP also clears TIMER_CNT to 0 at the same edge.
  - Counter wrap at 2^TIMER_WIDTH-1 is unreachable because CMP caps it.
- Reset mid-operation: all state returns to reset values immediately, and a pending flag is lost. If PortIn is nonzero at reset release, IN_CHG sets on the 3rd edge after release.

Optional Feature:
- Macro MMIO_IRQ_EN, when defined:
  - Adds IRQ_MASK register at offset 0x14 (read/write, bits[1:0], reset 0).
  - Adds output port irq (1 bit) = |(STATUS[1:0] & IRQ_MASK), registered, so it asserts one cycle after the flag sets.
- When not defined: no irq port, and 0x14 reads 0.

Decomposition:
- Package mmio_pkg holds:
  - Offset constants OFF_PORT_OUT, OFF_PORT_IN, OFF_STATUS, OFF_TIMER_CMP, OFF_TIMER_CNT, OFF_IRQ_MASK.
  - STATUS bit indices STS_IN_CHG, STS_TMR_EXP.
  - Window size constant MMIO_WINDOW_BYTES=32.
- Sub-module mmio_input_sync: s1/s2/s3 chain, outputs sync value and change pulse, parameterized by IN_WIDTH.

Test Plan:
- Reset low mid-run with PortOut=0xDEAD_BEEF, CMP=5 -> PortOut=0, TIMER_CNT=0, STATUS=0 immediately, without waiting for a clock.
- Store 0x0000_00A5 to 0x1001_0100, then load the same address -> PortOut=0xA5 after the edge; ReadData=0xA5, Hit=1. Load 0x1001_0200 -> Hit=0, ReadData=0.
- PortIn 0x00→0x3C -> PORT_IN reads 0x3C after 2 edges; STATUS reads 0x1 after 3 edges; a second read returns 0x0.
- Write TIMER_CMP=3 -> TIMER_CNT goes 0,1,2,3,0; TMR_EXP=1 on the 4th edge. A STATUS read in the same cycle a new expiry occurs -> the flag remains 1.
- Store to PORT_IN offset 0x04 with 0xFFFF_FFFF -> no state change; PORT_IN still reflects the synced PortIn.
- With MMIO_IRQ_EN: IRQ_MASK=0x2, CMP=1 -> irq=1 one cycle after TMR_EXP sets; reading STATUS -> irq drops the cycle after the clear.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register offsets (word index
// Address[4:2]), STATUS bit positions and the I/O window size.
package mmio_pkg;

    localparam int unsigned MMIO_WINDOW_BYTES = 32;

    localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
    localparam logic [2:0] OFF_PORT_IN   = 3'd1;
    localparam logic [2:0] OFF_STATUS    = 3'd2;
    localparam logic [2:0] OFF_TIMER_CMP = 3'd3;
    localparam logic [2:0] OFF_TIMER_CNT = 3'd4;
    localparam logic [2:0] OFF_IRQ_MASK  = 3'd5;

    localparam int unsigned STS_IN_CHG  = 0;
    localparam int unsigned STS_TMR_EXP = 1;

endpackage

// File: rtl/mmio_input_sync.sv
// Two-flop synchronizer for the external input port plus a previous-value
// flop, producing the synchronized value and a one-cycle change indication.
module mmio_input_sync #(
    parameter int unsigned IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] async_in,
    output logic [IN_WIDTH-1:0] sync_val,
    output logic                changed
);

    logic [IN_WIDTH-1:0] s1_r;
    logic [IN_WIDTH-1:0] s2_r;
    logic [IN_WIDTH-1:0] s3_r;

    // Synchronizer chain; s3 holds the previous synchronized value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r <= '0;
            s2_r <= '0;
            s3_r <= '0;
        end else begin
            s1_r <= async_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign sync_val = s2_r;
    assign changed  = (s2_r != s3_r);

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO target on the MIPS data-memory bus: PortOut, synchronized PortIn,
// compare timer and sticky STATUS. Optional interrupt logic under MMIO_IRQ_EN.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0100,
    parameter int unsigned IN_WIDTH    = 8,
    parameter int unsigned TIMER_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         ReadData,
    output logic                Hit,
    output logic [31:0]         PortOut
`ifdef MMIO_IRQ_EN
    ,
    output logic                irq
`endif
);

    logic                   hit_s;
    logic [2:0]             offset_s;
    logic                   wr_en_s;
    logic                   rd_en_s;
    logic [IN_WIDTH-1:0]    sync_val_s;
    logic                   in_chg_s;
    logic                   tmr_exp_s;
    logic                   cmp_wr_s;
    logic                   status_clr_s;
    logic [1:0]             status_set_s;
    logic [1:0]             status_nxt_s;
    logic [TIMER_WIDTH-1:0] cnt_nxt_s;
    logic [31:0]            port_out_r;
    logic [TIMER_WIDTH-1:0] cmp_r;
    logic [TIMER_WIDTH-1:0] cnt_r;
    logic [1:0]             status_r;
    logic                   unused_addr_s;
`ifdef MMIO_IRQ_EN
    logic [1:0]             irq_mask_r;
    logic                   irq_r;
`endif

    // Byte lane bits are irrelevant: registers are whole words
    assign unused_addr_s = ^Address[1:0];

    assign hit_s    = (Address[31:5] == BASE_ADDR[31:5]);
    assign offset_s = Address[4:2];
    assign wr_en_s  = MemWrite & hit_s;
    assign rd_en_s  = MemRead & hit_s;
    assign cmp_wr_s = wr_en_s && (offset_s == OFF_TIMER_CMP);

    mmio_input_sync #(
        .IN_WIDTH (IN_WIDTH)
    ) u_input_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (PortIn),
        .sync_val (sync_val_s),
        .changed  (in_chg_s)
    );

    // Timer next state; a CMP write restarts the count from zero
    always_comb begin
        cnt_nxt_s = cnt_r;
        tmr_exp_s = (cmp_r != '0) && (cnt_r == cmp_r);
        if (cmp_wr_s) begin
            cnt_nxt_s = '0;
        end else if (cmp_r == '0) begin
            cnt_nxt_s = '0;
        end else if (tmr_exp_s) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + TIMER_WIDTH'(1);
        end
    end

    // Sticky flags: a set in the same cycle as a clear-on-read wins
    always_comb begin
        status_set_s              = 2'b00;
        status_set_s[STS_IN_CHG]  = in_chg_s;
        status_set_s[STS_TMR_EXP] = tmr_exp_s;
        status_clr_s              = rd_en_s && (offset_s == OFF_STATUS);
        status_nxt_s              = status_set_s | (status_r & ~{2{status_clr_s}});
    end

    // Architectural registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_r <= 32'd0;
            cmp_r      <= '0;
            cnt_r      <= '0;
            status_r   <= 2'b00;
        end else begin
            if (wr_en_s && (offset_s == OFF_PORT_OUT)) begin
                port_out_r <= WriteData;
            end
            if (cmp_wr_s) begin
                cmp_r <= TIMER_WIDTH'(WriteData);
            end
            cnt_r    <= cnt_nxt_s;
            status_r <= status_nxt_s;
        end
    end

`ifdef MMIO_IRQ_EN
    // Interrupt mask and registered interrupt output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_mask_r <= 2'b00;
            irq_r      <= 1'b0;
        end else begin
            if (wr_en_s && (offset_s == OFF_IRQ_MASK)) begin
                irq_mask_r <= WriteData[1:0];
            end
            irq_r <= |(status_r & irq_mask_r);
        end
    end

    assign irq = irq_r;
`endif

    // Combinational read mux; returns pre-write contents on a same-cycle store
    always_comb begin
        ReadData = 32'd0;
        if (rd_en_s) begin
            case (offset_s)
                OFF_PORT_OUT:  ReadData = port_out_r;
                OFF_PORT_IN:   ReadData = 32'(sync_val_s);
                OFF_STATUS:    ReadData = {30'd0, status_r};
                OFF_TIMER_CMP: ReadData = 32'(cmp_r);
                OFF_TIMER_CNT: ReadData = 32'(cnt_r);
`ifdef MMIO_IRQ_EN
                OFF_IRQ_MASK:  ReadData = {30'd0, irq_mask_r};
`endif
                default:       ReadData = 32'd0;
            endcase
        end else begin
            ReadData = 32'd0;
        end
    end

    assign Hit     = hit_s;
    assign PortOut = port_out_r;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed self-checking bench for mmio_port_responder; IRQ scenario is
// compiled only when MMIO_IRQ_EN is defined.
module tb_mmio_port_responder;

    localparam logic [31:0] A_PORT_OUT = 32'h1001_0100;
    localparam logic [31:0] A_PORT_IN  = 32'h1001_0104;
    localparam logic [31:0] A_STATUS   = 32'h1001_0108;
    localparam logic [31:0] A_CMP      = 32'h1001_010C;
    localparam logic [31:0] A_CNT      = 32'h1001_0110;
    localparam logic [31:0] A_MASK     = 32'h1001_0114;
    localparam logic [31:0] A_RSVD     = 32'h1001_0118;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    mmio_port_responder dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortOut   (PortOut)
`ifdef MMIO_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        tick();
        MemWrite  = 1'b0;
    endtask

    // Read without letting an edge pass, so STATUS is not cleared
    task automatic peek(input logic [31:0] addr, output logic [31:0] data);
        Address  = addr;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        #1;
        data     = ReadData;
        MemRead  = 1'b0;
    endtask

    // Read held across one edge (clear-on-read takes effect)
    task automatic rd_clk(input logic [31:0] addr, output logic [31:0] data);
        Address  = addr;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        #1;
        data     = ReadData;
        tick();
        MemRead  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0;
        Address = 32'd0; WriteData = 32'd0; MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
        #12;
        checks++;
        if (PortOut !== 32'd0) begin errors++; $display("FAIL reset_portout: got %h want %h", PortOut, 32'd0); end
        peek(A_CNT, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %h want %h", d, 32'd0); end
        peek(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_status: got %h want %h", d, 32'd0); end
`ifdef MMIO_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_port_out();
        logic [31:0] d;
        do_write(A_PORT_OUT, 32'h0000_00A5);
        checks++;
        if (PortOut !== 32'h0000_00A5) begin errors++; $display("FAIL portout_write: got %h want %h", PortOut, 32'h0000_00A5); end
        peek(A_PORT_OUT, d);
        checks++;
        if (d !== 32'h0000_00A5) begin errors++; $display("FAIL portout_read: got %h want %h", d, 32'h0000_00A5); end
        Address = A_PORT_OUT; MemRead = 1'b1; #1;
        checks++;
        if (Hit !== 1'b1) begin errors++; $display("FAIL hit_in_window: got %b want 1", Hit); end
        MemRead = 1'b0; #1;
        checks++;
        if (ReadData !== 32'd0) begin errors++; $display("FAIL read_no_memread: got %h want 0", ReadData); end
        peek(32'h1001_0103, d);
        checks++;
        if (d !== 32'h0000_00A5) begin errors++; $display("FAIL byte_bits_ignored: got %h want %h", d, 32'h0000_00A5); end
        Address = 32'h1001_0200; MemRead = 1'b1; #1;
        checks++;
        if (Hit !== 1'b0 || ReadData !== 32'd0) begin
            errors++; $display("FAIL miss_outside: hit %b data %h want hit 0 data 0", Hit, ReadData);
        end
        MemRead = 1'b0;
    endtask

    task automatic test_port_in();
        logic [31:0] d;
        PortIn = 8'h3C;
        tick();
        peek(A_PORT_IN, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL portin_edge1: got %h want 0", d); end
        tick();
        peek(A_PORT_IN, d);
        checks++;
        if (d !== 32'h0000_003C) begin errors++; $display("FAIL portin_edge2: got %h want %h", d, 32'h0000_003C); end
        peek(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL inchg_edge2: got %h want 0", d); end
        tick();
        rd_clk(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL inchg_edge3: got %h want 1", d); end
        peek(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL inchg_cleared: got %h want 0", d); end
    endtask

    task automatic test_write_readonly();
        logic [31:0] d;
        do_write(A_PORT_IN, 32'hFFFF_FFFF);
        do_write(A_STATUS, 32'hFFFF_FFFF);
        do_write(A_CNT, 32'hFFFF_FFFF);
        do_write(A_RSVD, 32'hFFFF_FFFF);
`ifndef MMIO_IRQ_EN
        do_write(A_MASK, 32'hFFFF_FFFF);
        peek(A_MASK, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ro_mask_absent: got %h want 0", d); end
`endif
        checks++;
        if (PortOut !== 32'h0000_00A5) begin errors++; $display("FAIL ro_portout: got %h want %h", PortOut, 32'h0000_00A5); end
        peek(A_PORT_IN, d);
        checks++;
        if (d !== 32'h0000_003C) begin errors++; $display("FAIL ro_portin: got %h want %h", d, 32'h0000_003C); end
        peek(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ro_status: got %h want 0", d); end
        peek(A_CNT, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ro_cnt: got %h want 0", d); end
        peek(A_CMP, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ro_cmp: got %h want 0", d); end
        peek(A_RSVD, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ro_rsvd: got %h want 0", d); end
    endtask

    task automatic test_back_to_back();
        Address   = A_PORT_OUT;
        WriteData = 32'h0000_1234;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        #1;
        checks++;
        if (ReadData !== 32'h0000_00A5) begin errors++; $display("FAIL rw_prewrite: got %h want %h", ReadData, 32'h0000_00A5); end
        tick();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        checks++;
        if (PortOut !== 32'h0000_1234) begin errors++; $display("FAIL rw_postwrite: got %h want %h", PortOut, 32'h0000_1234); end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        logic [31:0] exp_cnt [4];
        logic [31:0] exp_sts [4];
        exp_cnt = '{32'd1, 32'd2, 32'd3, 32'd0};
        exp_sts = '{32'd0, 32'd0, 32'd0, 32'd2};
        do_write(A_CMP, 32'd3);
        peek(A_CNT, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL tmr_start: got %h want 0", d); end
        peek(A_CMP, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL tmr_cmp_read: got %h want 3", d); end
        for (int k = 0; k < 4; k++) begin
            tick();
            peek(A_CNT, d);
            checks++;
            if (d !== exp_cnt[k]) begin errors++; $display("FAIL tmr_cnt_e%0d: got %h want %h", k + 1, d, exp_cnt[k]); end
            peek(A_STATUS, d);
            checks++;
            if (d !== exp_sts[k]) begin errors++; $display("FAIL tmr_sts_e%0d: got %h want %h", k + 1, d, exp_sts[k]); end
        end
        tick();
        tick();
        tick();
        peek(A_CNT, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL tmr_cnt_e7: got %h want 3", d); end
        rd_clk(A_STATUS, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL tmr_read_at_expiry: got %h want 2", d); end
        peek(A_STATUS, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL tmr_set_wins: got %h want 2", d); end
        rd_clk(A_STATUS, d);
        peek(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL tmr_clear: got %h want 0", d); end
        do_write(A_CMP, 32'd0);
        tick();
        peek(A_CNT, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL tmr_disabled: got %h want 0", d); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        do_write(A_PORT_OUT, 32'hDEAD_BEEF);
        do_write(A_CMP, 32'd5);
        for (int k = 0; k < 6; k++) tick();
        peek(A_STATUS, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL mid_pre_status: got %h want 2", d); end
        PortIn = 8'h55;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (PortOut !== 32'd0) begin errors++; $display("FAIL mid_portout: got %h want 0", PortOut); end
        peek(A_CNT, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL mid_cnt: got %h want 0", d); end
        peek(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL mid_status: got %h want 0", d); end
        peek(A_CMP, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL mid_cmp: got %h want 0", d); end
        tick();
        reset = 1'b1;
        tick();
        tick();
        peek(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL rel_inchg_e2: got %h want 0", d); end
        tick();
        rd_clk(A_STATUS, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL rel_inchg_e3: got %h want 1", d); end
    endtask

`ifdef MMIO_IRQ_EN
    task automatic test_irq();
        logic [31:0] d;
        do_write(A_MASK, 32'h0000_0002);
        peek(A_MASK, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL irq_mask_read: got %h want 2", d); end
        do_write(A_CMP, 32'd1);
        tick();
        tick();
        peek(A_STATUS, d);
        checks++;
        if (d !== 32'd2 || irq !== 1'b0) begin errors++; $display("FAIL irq_flag_set: status %h irq %b want 2/0", d, irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b want 1", irq); end
        do_write(A_CMP, 32'd0);
        rd_clk(A_STATUS, d);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_at_clear: got %b want 1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", irq); end
    endtask
`endif

    initial begin
        test_reset();
        test_port_out();
        test_port_in();
        test_write_readonly();
        test_back_to_back();
        test_timer();
        test_reset_mid_run();
`ifdef MMIO_IRQ_EN
        test_irq();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
